// File: rtl/gate_game_pkg.sv
// Shared types and helpers for the logic-gate trainer sequencer: state encoding,
// gate index constants and the selector code mapping.
package gate_game_pkg;

    localparam int MAX_GATES = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK  = 3'd1,
        PLAY  = 3'd2,
        BLANK = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [3:0] GATE_AND  = 4'd0;
    localparam logic [3:0] GATE_OR   = 4'd1;
    localparam logic [3:0] GATE_NAND = 4'd2;
    localparam logic [3:0] GATE_NOR  = 4'd3;
    localparam logic [3:0] GATE_XOR  = 4'd4;
    localparam logic [3:0] GATE_XNOR = 4'd5;
    localparam logic [3:0] GATE_SR   = 4'd6;
    localparam logic [3:0] GATE_T    = 4'd7;
    localparam logic [3:0] GATE_D    = 4'd8;

    // The selector treats AND as the all-zero code and every other gate as one-hot.
    function automatic logic [7:0] idx_to_code(input logic [3:0] idx);
        logic [7:0] code;
        if (idx == GATE_AND) begin
            code = 8'd0;
        end else begin
            code = 8'd1 << (idx - 4'd1);
        end
        return code;
    endfunction

endpackage

// File: rtl/gate_round_scheduler_if.sv
// Player-input and game-status bundle between the key/random front end, the
// round scheduler and the selector/VGA back end.
interface gate_round_scheduler_if;
    logic       switch_pulse;
    logic       confirm_pulse;
    logic [3:0] rand_idx;
    logic [3:0] selected_gate;
    logic [3:0] current_gate;
    logic [7:0] gate_code;
    logic [8:0] completed_gate;
    logic       timer_en;
    logic       vga_blankout;
    logic [7:0] miss_count;
    logic       game_done;

    modport master (
        output switch_pulse, confirm_pulse, rand_idx,
        input  selected_gate, current_gate, gate_code, completed_gate,
        input  timer_en, vga_blankout, miss_count, game_done
    );

    modport slave (
        input  switch_pulse, confirm_pulse, rand_idx,
        output selected_gate, current_gate, gate_code, completed_gate,
        output timer_en, vga_blankout, miss_count, game_done
    );
endinterface

// File: rtl/gate_round_scheduler_penalty_timer.sv
// Loadable down-counter with a zero flag; counts down to zero and holds there.
module penalty_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority over decrement.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/gate_round_scheduler.sv
// Round sequencer for the logic-gate trainer. Optional per-gate time limit is
// enabled by defining GATE_TIMEOUT_EN.
import gate_game_pkg::*;

module gate_round_scheduler #(
    parameter int NUM_GATES      = 9,
    parameter int BLANK_CYCLES   = 25000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic                  clk,
    input  logic                  reset,
    gate_round_scheduler_if.slave bus
);

    localparam int         PEN_W     = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(BLANK_CYCLES - 1);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_GATES - 1);
    localparam logic [8:0] FULL_MASK = 9'((32'd1 << NUM_GATES) - 32'd1);

    state_e     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] cur_q, cur_d;
    logic [7:0] code_q;
    logic [8:0] mask_q, mask_d;
    logic [7:0] miss_q, miss_d;
    logic       timer_en_q;
    logic       blank_q;
    logic       done_q;

    logic [3:0] ptr_rand_s;
    logic [8:0] new_mask_s;
    logic       pen_load_s;
    logic       pen_dec_s;
    logic       pen_zero_s;
    logic       timeout_s;

    assign ptr_rand_s = 4'({28'd0, bus.rand_idx} % 32'(NUM_GATES));
    assign new_mask_s = mask_q | (9'd1 << cur_q);
    assign pen_dec_s  = (state_q == BLANK);

    penalty_timer #(.WIDTH(PEN_W)) u_penalty (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pen_load_s),
        .load_val_i (PEN_LOAD),
        .dec_i      (pen_dec_s),
        .zero_o     (pen_zero_s)
    );

`ifdef GATE_TIMEOUT_EN
    logic to_load_s;
    logic to_zero_s;

    // Restarts on every entry into PLAY, so the limit applies per attempt.
    assign to_load_s = (state_d == PLAY) && (state_q != PLAY);
    assign timeout_s = to_zero_s && (state_q == PLAY);

    penalty_timer #(.WIDTH(29)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load_i     (to_load_s),
        .load_val_i (29'(TIMEOUT_CYCLES - 1)),
        .dec_i      (state_q == PLAY),
        .zero_o     (to_zero_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and datapath updates; in PLAY confirm beats timeout beats switch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        cur_d      = cur_q;
        mask_d     = mask_q;
        miss_d     = miss_q;
        pen_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.confirm_pulse) begin
                    state_d = PICK;
                    ptr_d   = ptr_rand_s;
                    mask_d  = 9'd0;
                    miss_d  = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            PICK: begin
                if (!mask_q[ptr_q]) begin
                    cur_d   = ptr_q;
                    state_d = PLAY;
                end else if (ptr_q == LAST_IDX) begin
                    ptr_d = 4'd0;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
            PLAY: begin
                if (bus.confirm_pulse && (sel_q == cur_q)) begin
                    mask_d = new_mask_s;
                    if (new_mask_s == FULL_MASK) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_rand_s;
                        state_d = PICK;
                    end
                end else if (bus.confirm_pulse || timeout_s) begin
                    miss_d     = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
                    pen_load_s = 1'b1;
                    state_d    = BLANK;
                end else if (bus.switch_pulse) begin
                    sel_d = (sel_q == LAST_IDX) ? 4'd0 : sel_q + 4'd1;
                end else begin
                    state_d = PLAY;
                end
            end
            BLANK: begin
                if (pen_zero_s) begin
                    state_d = PLAY;
                end else begin
                    state_d = BLANK;
                end
            end
            DONE: begin
                if (bus.confirm_pulse) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 4'd0;
            sel_q      <= 4'd0;
            cur_q      <= 4'd0;
            code_q     <= 8'd0;
            mask_q     <= 9'd0;
            miss_q     <= 8'd0;
            timer_en_q <= 1'b0;
            blank_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            cur_q      <= cur_d;
            code_q     <= idx_to_code(cur_d);
            mask_q     <= mask_d;
            miss_q     <= miss_d;
            timer_en_q <= (state_d == PICK) || (state_d == PLAY) || (state_d == BLANK);
            blank_q    <= (state_d == BLANK);
            done_q     <= (state_d == DONE);
        end
    end

    assign bus.selected_gate  = sel_q;
    assign bus.current_gate   = cur_q;
    assign bus.gate_code      = code_q;
    assign bus.completed_gate = mask_q;
    assign bus.timer_en       = timer_en_q;
    assign bus.vga_blankout   = blank_q;
    assign bus.miss_count     = miss_q;
    assign bus.game_done      = done_q;

endmodule

// File: tb/tb_gate_round_scheduler.sv
// Randomized scoreboard bench for gate_round_scheduler against a round-level model.
module tb_gate_round_scheduler;

    localparam int NG = 9;
    localparam int BC = 4;
    localparam int TC = 10;
    localparam int TOTAL = 8000;

    localparam int M_IDLE = 0, M_PICK = 1, M_PLAY = 2, M_BLANK = 3, M_DONE = 4;

    logic clk = 1'b0;
    logic reset;

    gate_round_scheduler_if bus();

    gate_round_scheduler #(
        .NUM_GATES      (NG),
        .BLANK_CYCLES   (BC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel, cur, code, mask, ten, blk, miss, done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Round-level model: what the player sees, not how the sequencer steps.
    int     m_mode, m_sel, m_cur, m_miss;
    int     m_pick_left, m_pick_tgt, m_blank_left, m_age;
    bit [8:0] m_mask;
    int     games_done = 0;
    bit     saw_sat = 1'b0;

    task automatic start_pick(input int s);
        for (int d = 0; d < NG; d++) begin
            int idx;
            idx = (s + d) % NG;
            if (!m_mask[idx]) begin
                m_pick_left = d + 1;
                m_pick_tgt  = idx;
                break;
            end
        end
        m_mode = M_PICK;
    endtask

    task automatic take_miss();
        m_miss       = (m_miss < 255) ? m_miss + 1 : 255;
        m_blank_left = BC;
        m_mode       = M_BLANK;
        if (m_miss == 255) saw_sat = 1'b1;
    endtask

    task automatic model_step(input bit rst, input bit sw, input bit cf, input int ri);
        exp_t e;
        bit   to_hit;
        if (rst) begin
            m_mode = M_IDLE; m_sel = 0; m_cur = 0; m_miss = 0; m_mask = '0;
            m_age = 0; m_pick_left = 0; m_blank_left = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (cf) begin
                    m_mask = '0;
                    m_miss = 0;
                    start_pick(ri % NG);
                end
                M_PICK: begin
                    m_pick_left--;
                    if (m_pick_left == 0) begin
                        m_cur  = m_pick_tgt;
                        m_mode = M_PLAY;
                        m_age  = 0;
                    end
                end
                M_PLAY: begin
`ifdef GATE_TIMEOUT_EN
                    to_hit = (m_age == TC - 1);
`else
                    to_hit = 1'b0;
`endif
                    if (cf && m_sel == m_cur) begin
                        m_mask[m_cur] = 1'b1;
                        if (m_mask == 9'((1 << NG) - 1)) begin
                            m_mode = M_DONE;
                            games_done++;
                        end else begin
                            start_pick(ri % NG);
                        end
                    end else if (cf || to_hit) begin
                        take_miss();
                    end else begin
                        if (sw) m_sel = (m_sel + 1) % NG;
                        m_age++;
                    end
                end
                M_BLANK: begin
                    m_blank_left--;
                    if (m_blank_left == 0) begin
                        m_mode = M_PLAY;
                        m_age  = 0;
                    end
                end
                M_DONE: if (cf) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
        e.sel  = m_sel;
        e.cur  = m_cur;
        e.code = (m_cur == 0) ? 0 : (1 << (m_cur - 1));
        e.mask = int'(m_mask);
        e.ten  = (m_mode == M_PICK || m_mode == M_PLAY || m_mode == M_BLANK) ? 1 : 0;
        e.blk  = (m_mode == M_BLANK) ? 1 : 0;
        e.miss = m_miss;
        e.done = (m_mode == M_DONE) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic check_field(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp_v);
        end
    endtask

    // Monitor: one registered response per clock, compared against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_field("selected_gate",  int'(bus.selected_gate),  e.sel);
                check_field("current_gate",   int'(bus.current_gate),   e.cur);
                check_field("gate_code",      int'(bus.gate_code),      e.code);
                check_field("completed_gate", int'(bus.completed_gate), e.mask);
                check_field("timer_en",       int'(bus.timer_en),       e.ten);
                check_field("vga_blankout",   int'(bus.vga_blankout),   e.blk);
                check_field("miss_count",     int'(bus.miss_count),     e.miss);
                check_field("game_done",      int'(bus.game_done),      e.done);
            end
        end
    end

    // Driver: guided hits, then forced misses, then unconstrained noise with resets.
    initial begin
        bit rst, sw, cf;
        int ri;
        reset = 1'b1;
        bus.switch_pulse  = 1'b0;
        bus.confirm_pulse = 1'b0;
        bus.rand_idx      = 4'd0;
        for (int cyc = 0; cyc < TOTAL; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            sw  = ($urandom_range(0, 3) == 0);
            cf  = ($urandom_range(0, 3) == 0);
            ri  = int'($urandom_range(0, 15));
            if (cyc < 4) begin
                rst = 1'b1;
            end else if (cyc < 3000) begin
                if (m_mode == M_PLAY) begin
                    if (m_sel != m_cur) begin
                        sw = ($urandom_range(0, 9) != 0);
                        cf = ($urandom_range(0, 19) == 0);
                    end else begin
                        cf = ($urandom_range(0, 9) < 7);
                        sw = ($urandom_range(0, 9) == 0);
                    end
                end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
                    cf = ($urandom_range(0, 2) == 0);
                end
            end else if (cyc < 6000) begin
                if (m_mode == M_PLAY) begin
                    sw = (m_sel == m_cur);
                    cf = (m_sel != m_cur) && ($urandom_range(0, 4) != 0);
                end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
                    cf = ($urandom_range(0, 2) == 0);
                end
            end else begin
                rst = ($urandom_range(0, 299) == 0);
            end
            reset             = rst;
            bus.switch_pulse  = sw;
            bus.confirm_pulse = cf;
            bus.rand_idx      = 4'(ri);
            model_step(rst, sw, cf, ri);
        end
        @(negedge clk);
        bus.switch_pulse  = 1'b0;
        bus.confirm_pulse = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
        end
        checks++;
        if (games_done == 0) begin
            errors++;
            $display("FAIL cov_done: actual=%0d games completed required>=1", games_done);
        end
        checks++;
        if (!saw_sat) begin
            errors++;
            $display("FAIL cov_sat: actual=%0d saturation seen required=1", saw_sat);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
